// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush scheduler.
package pipeline_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

    localparam int DIV_CYCLES_DEF = 32;
    localparam int MUL_CYCLES_DEF = 2;

    localparam logic [31:0] STALL_COUNT_MAX = 32'hFFFF_FFFF;

    // Counter increment that sticks at the top value instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == STALL_COUNT_MAX) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard inputs and stall/flush controls between the pipeline datapath and the scheduler.
interface pipeline_stall_ctrl_if;

    logic [4:0]  D_Rs1;
    logic [4:0]  D_Rs2;
    logic [4:0]  E_Rd;
    logic        E_MemRead;
    logic        E_MulDiv;
    logic        E_IsDiv;
    logic        E_PCSrc;

    logic        StallF;
    logic        StallD;
    logic        StallE;
    logic        FlushD;
    logic        FlushE;
    logic        FlushM;
    logic        MD_Start;
    logic        MD_Done;
    logic [31:0] StallCount;

    modport master (
        output D_Rs1, D_Rs2, E_Rd, E_MemRead, E_MulDiv, E_IsDiv, E_PCSrc,
        input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
        input  MD_Start, MD_Done, StallCount
    );

    modport slave (
        input  D_Rs1, D_Rs2, E_Rd, E_MemRead, E_MulDiv, E_IsDiv, E_PCSrc,
        output StallF, StallD, StallE, FlushD, FlushE, FlushM,
        output MD_Start, MD_Done, StallCount
    );

endinterface

// File: rtl/md_cycle_counter.sv
// Loadable down-counter tracking remaining M/D unit occupancy; stops at zero.
module md_cycle_counter #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic [W-1:0] value,
    output logic         is_zero
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - W'(1);
        end
    end

    assign value   = count_reg;
    assign is_zero = (count_reg == '0);

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush scheduler: load-use stalls, branch flushes and multi-cycle M/D sequencing.
module pipeline_stall_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipeline_stall_ctrl_if.slave  hz
);

    localparam int CNT_W = $clog2(DIV_CYCLES + 1);

    md_state_e        state_reg, state_next;
    logic [31:0]      stall_count_reg;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_load_value, cnt_value;
    logic             load_use;
    logic             stall_f, stall_d, stall_e;
    logic             flush_d, flush_e, flush_m;
    logic             md_start, md_done;

    assign load_use = hz.E_MemRead && (hz.E_Rd != 5'd0) &&
                      ((hz.E_Rd == hz.D_Rs1) || (hz.E_Rd == hz.D_Rs2));

    // Counter holds the remaining RUN cycles before the result is valid.
    assign cnt_load_value = hz.E_IsDiv ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);

    md_cycle_counter #(
        .W(CNT_W)
    ) u_md_cycle_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .dec        (cnt_dec),
        .value      (cnt_value),
        .is_zero    (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        stall_f    = 1'b0;
        stall_d    = 1'b0;
        stall_e    = 1'b0;
        flush_d    = 1'b0;
        flush_e    = 1'b0;
        flush_m    = 1'b0;
        md_start   = 1'b0;
        md_done    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (hz.E_MulDiv) begin
                    md_start   = 1'b1;
                    stall_f    = 1'b1;
                    stall_d    = 1'b1;
                    stall_e    = 1'b1;
                    flush_m    = 1'b1;
                    cnt_load   = 1'b1;
                    state_next = RUN;
                end else if (hz.E_PCSrc) begin
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                end else if (load_use) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                end
            end
            RUN: begin
                // Execute is frozen, so branch and load-use inputs are stale here.
                if (!cnt_zero) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    stall_e = 1'b1;
                    flush_m = 1'b1;
                    cnt_dec = 1'b1;
                end else begin
                    md_done    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (!rst_n) begin
            stall_f  = 1'b0;
            stall_d  = 1'b0;
            stall_e  = 1'b0;
            flush_d  = 1'b0;
            flush_e  = 1'b0;
            flush_m  = 1'b0;
            md_start = 1'b0;
            md_done  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_reg <= '0;
        end else if (stall_d) begin
            stall_count_reg <= sat_inc(stall_count_reg);
        end
    end

    // A loaded occupancy can never exceed the longest (divide) sequence.
    assert property (@(posedge clk) disable iff (!rst_n)
        (state_reg == RUN) |-> (cnt_value < CNT_W'(DIV_CYCLES)));

    assign hz.StallF     = stall_f;
    assign hz.StallD     = stall_d;
    assign hz.StallE     = stall_e;
    assign hz.FlushD     = flush_d;
    assign hz.FlushE     = flush_e;
    assign hz.FlushM     = flush_m;
    assign hz.MD_Start   = md_start;
    assign hz.MD_Done    = md_done;
    assign hz.StallCount = stall_count_reg;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: directed cycles push expected outputs, a monitor compares.
module tb_pipeline_stall_ctrl;

    typedef struct {
        logic [7:0]  ctl;
        logic [31:0] cnt;
        string       name;
    } exp_t;

    // ctl bit order: StallF StallD StallE FlushD FlushE FlushM MD_Start MD_Done
    localparam logic [7:0] C_NONE   = 8'b0000_0000;
    localparam logic [7:0] C_LDUSE  = 8'b1100_1000;
    localparam logic [7:0] C_BRANCH = 8'b0001_1000;
    localparam logic [7:0] C_START  = 8'b1110_0110;
    localparam logic [7:0] C_BUSY   = 8'b1110_0100;
    localparam logic [7:0] C_DONE   = 8'b0000_0001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    pipeline_stall_ctrl_if hz_if();

    pipeline_stall_ctrl #(
        .DIV_CYCLES(32),
        .MUL_CYCLES(2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz_if)
    );

    always #5 clk = ~clk;

    exp_t        exp_q[$];
    logic [31:0] model_cnt = 32'd0;
    int          checks = 0;
    int          failures = 0;
    exp_t        mon_e;
    logic [7:0]  mon_ctl;
    logic [7:0]  rst_ctl;

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e   = exp_q.pop_front();
            mon_ctl = {hz_if.StallF, hz_if.StallD, hz_if.StallE, hz_if.FlushD,
                       hz_if.FlushE, hz_if.FlushM, hz_if.MD_Start, hz_if.MD_Done};
            checks++;
            if (mon_ctl !== mon_e.ctl || hz_if.StallCount !== mon_e.cnt) begin
                failures++;
                $display("FAIL %s ctl=%b cnt=%h required ctl=%b cnt=%h",
                         mon_e.name, mon_ctl, hz_if.StallCount, mon_e.ctl, mon_e.cnt);
            end else begin
                $display("ok   %s ctl=%b cnt=%h", mon_e.name, mon_ctl, hz_if.StallCount);
            end
        end
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: wait expired before the test sequence finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic step(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic memrd, input logic muldiv, input logic isdiv,
                        input logic pcsrc, input logic [7:0] ctl, input string name);
        hz_if.D_Rs1     = rs1;
        hz_if.D_Rs2     = rs2;
        hz_if.E_Rd      = rd;
        hz_if.E_MemRead = memrd;
        hz_if.E_MulDiv  = muldiv;
        hz_if.E_IsDiv   = isdiv;
        hz_if.E_PCSrc   = pcsrc;
        exp_q.push_back('{ctl, model_cnt, name});
        if (ctl[6] && model_cnt != 32'hFFFF_FFFF) model_cnt = model_cnt + 32'd1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        hz_if.D_Rs1 = 5'd5; hz_if.D_Rs2 = 5'd5; hz_if.E_Rd = 5'd5;
        hz_if.E_MemRead = 1'b1; hz_if.E_MulDiv = 1'b1;
        hz_if.E_IsDiv = 1'b1; hz_if.E_PCSrc = 1'b1;
        #2;
        rst_ctl = {hz_if.StallF, hz_if.StallD, hz_if.StallE, hz_if.FlushD,
                   hz_if.FlushE, hz_if.FlushM, hz_if.MD_Start, hz_if.MD_Done};
        checks++;
        if (rst_ctl !== C_NONE || hz_if.StallCount !== 32'd0) begin
            failures++;
            $display("FAIL rst_direct ctl=%b cnt=%h required ctl=%b cnt=%h",
                     rst_ctl, hz_if.StallCount, C_NONE, 32'd0);
        end else begin
            $display("ok   rst_direct ctl=%b cnt=%h", rst_ctl, hz_if.StallCount);
        end

        hz_if.D_Rs1 = '0; hz_if.D_Rs2 = '0; hz_if.E_Rd = '0;
        hz_if.E_MemRead = 1'b0; hz_if.E_MulDiv = 1'b0;
        hz_if.E_IsDiv = 1'b0; hz_if.E_PCSrc = 1'b0;
        @(posedge clk);
        #1;

        // Reset: outputs gated low even with active hazard inputs
        step(5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, C_NONE, "rst_state");
        rst_n = 1'b1;
        step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, "idle");

        // Load-use and its non-hazard variants
        step(5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, C_LDUSE, "ldu_rs2");
        step(5'd1, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, "ldu_bubble");
        step(5'd7, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, C_LDUSE, "ldu_rs1");
        step(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, C_NONE, "ldu_rd0");
        step(5'd4, 5'd6, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, C_NONE, "ldu_nomatch");

        // Branch outranks load-use
        step(5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, C_BRANCH, "br_ldu");
        step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, C_BRANCH, "br_only");

        // Divide: IsDiv/PCSrc/load-use changes during RUN must be ignored
        step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, C_START, "div_c0");
        for (int i = 1; i < 32; i++)
            step(5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, C_BUSY, $sformatf("div_c%0d", i));
        step(5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, C_DONE, "div_c32");
        step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, "div_after");

        // Back-to-back multiplies
        step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, C_START, "mul_a_c0");
        step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, C_BUSY,  "mul_a_c1");
        step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, C_DONE,  "mul_a_c2");
        step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, C_START, "mul_b_c3");
        step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, C_BUSY,  "mul_b_c4");
        step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, C_DONE,  "mul_b_c5");
        step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE,  "mul_after");

        // Reset in the middle of a divide
        step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, C_START, "rdiv_c0");
        for (int i = 1; i < 10; i++)
            step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, C_BUSY, $sformatf("rdiv_c%0d", i));
        rst_n = 1'b0;
        model_cnt = 32'd0;
        step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, C_NONE, "rdiv_rst");
        step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, C_NONE, "rdiv_rst_hold");
        rst_n = 1'b1;
        step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, "rdiv_post0");
        step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, "rdiv_post1");
        step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, C_START, "fresh_c0");
        step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, C_BUSY,  "fresh_c1");
        step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_DONE,  "fresh_c2");

        // Saturation of the stall counter
        force dut.stall_count_reg = 32'hFFFF_FFFE;
        #1;
        release dut.stall_count_reg;
        model_cnt = 32'hFFFF_FFFE;
        step(5'd9, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, C_LDUSE, "sat_0");
        step(5'd9, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, C_LDUSE, "sat_1");
        step(5'd9, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, C_LDUSE, "sat_2");
        step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE,  "sat_hold");

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Stall/flush scheduler for the RV32ICMFA 5-stage pipeline. It detects load-use hazards, flushes wrong-path instructions on taken branches and jumps, and sequences the multi-cycle M-extension multiply/divide unit in Execute. While that unit runs, it freezes F/D/E and bubbles Memory. It works alongside the forwarding unit: forwarding resolves ALU-to-ALU dependencies, and this block handles every case that needs a stall or flush.

## Interface
- DIV_CYCLES, 32: divide occupancy of the M/D unit, in cycles (≥1)
- MUL_CYCLES, 2: multiply occupancy, in cycles (≥1)
- clk  in  1  pipeline clock; all state on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- D_Rs1, D_Rs2  in  5  Decode-stage source registers
- E_Rd  in  5  Execute-stage destination register
- E_MemRead  in  1  the Execute-stage instruction is a load
- E_MulDiv  in  1  the Execute-stage instruction is an M-extension op
- E_IsDiv  in  1  the M op is div/divu/rem/remu (qualified by E_MulDiv)
- E_PCSrc  in  1  taken branch/jump resolved in Execute
- StallF, StallD, StallE  out  1  hold the PC, IF/ID and ID/EX registers
- FlushD, FlushE, FlushM  out  1  clear IF/ID, ID/EX and EX/MEM to a bubble
- MD_Start  out  1  one-cycle start pulse to the M/D unit
- MD_Done  out  1  M/D result valid this cycle; Execute advances
- StallCount  out  32  saturating count of cycles with StallD=1

## Operation
- FSM with two states, IDLE and RUN; a down-counter of width CNT_W = clog2(DIV_CYCLES+1).
- IDLE with E_MulDiv=1:
  - MD_Start=1; StallF=StallD=StallE=1, FlushM=1.
  - Counter loads (E_IsDiv ? DIV_CYCLES : MUL_CYCLES) - 1; next state RUN.
- RUN with counter ≠ 0:
  - StallF/D/E=1, FlushM=1; counter decrements.
  - E_PCSrc and the load-use terms are ignored.
- RUN with counter = 0:
  - MD_Done=1; all stalls and flushes are 0; next state IDLE.
- IDLE with no M op: stalls/flushes are evaluated combinationally, in priority order:
  1. E_PCSrc: FlushD=FlushE=1, no stall.
  2. Load-use: E_MemRead=1, E_Rd≠0, and E_Rd equals D_Rs1 or D_Rs2. Drives StallF=StallD=1, FlushE=1.
  3. Otherwise all stall/flush outputs are 0.
- A new M op reaching Execute directly after MD_Done starts a fresh sequence (back-to-back ops are legal).
- StallCount increments on every cycle with StallD=1 and holds at 32'hFFFF_FFFF.

## Timing
- Reset (rst_n=0, async):
  - State IDLE, counter 0, StallCount 0.
  - All 1-bit outputs are forced to 0 while rst_n is low.
- Reset mid-RUN aborts the sequence immediately. MD_Start is not reissued; the next E_MulDiv after release starts fresh.
- The M/D occupancy for N = selected cycle count:
  - MD_Start at cycle 0; RUN during cycles 1..N; MD_Done at cycle N.
  - Execute stalls for cycles 0..N-1 (N cycles) and advances at the cycle N edge.
- N=1: MD_Start at cycle 0, MD_Done at cycle 1, one stall cycle.
- Load-use costs exactly 1 stall cycle, because E_MemRead has cleared after the bubble.
- Branch penalty is 2 flushed slots, with no state change.
- E_IsDiv is sampled only on the IDLE→RUN transition.

## Structure
- Shared package/header `pipeline_ctrl_pkg` holds:
  - State encodings (IDLE=1'b0, RUN=1'b1).
  - Default DIV_CYCLES/MUL_CYCLES.
  - The StallCount saturation constant.
- One natural sub-module, `md_cycle_counter`: loadable down-counter with a zero flag (load, dec, value, is_zero). The FSM and hazard logic stay in the top module.

## Test plan
- Load-use: E_MemRead=1, E_Rd=5, D_Rs2=5 for one cycle → StallF=StallD=FlushE=1 for 1 cycle; StallCount +1. Same stimulus with E_Rd=0 → all outputs 0.
- Branch: E_PCSrc=1 together with the load-use condition → FlushD=FlushE=1, StallD=0.
- Divide: E_MulDiv=E_IsDiv=1 held → MD_Start at cycle 0, stalls and FlushM high for 32 cycles, MD_Done at cycle 32; StallCount=32.
- Back-to-back multiplies with MUL_CYCLES=2: two MD_Start pulses 3 cycles apart, MD_Done at cycles 2 and 5.
- Reset mid-divide: rst_n low at cycle 10 → outputs 0 immediately. After release with E_MulDiv=0 → IDLE, no MD_Done.
- Saturation: force StallCount near 32'hFFFF_FFFE, then 3 stall cycles → holds at 32'hFFFF_FFFF.
